// File: rtl/rgb_pwm_ctrl_if.sv
// Duty-write port of rgb_pwm_ctrl: host drives valid/chan/duty, controller returns ready.
interface rgb_pwm_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             wr_valid;
  logic             wr_ready;
  logic [1:0]       wr_chan;
  logic [WIDTH-1:0] wr_duty;

  modport master (output wr_valid, wr_chan, wr_duty, input wr_ready);
  modport slave  (input wr_valid, wr_chan, wr_duty, output wr_ready);
endinterface

// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: source-side controller for the SB_RGBA_DRV LED driver.
// Sequences CURREN ahead of RGBLEDEN, generates three PWM streams and
// double-buffers host duty writes so they only take effect at period boundaries.
module rgb_pwm_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4,
  parameter int SETTLE   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  rgb_pwm_ctrl_if.slave wr,
  output logic          curren,
  output logic          rgbleden,
  output logic          pwm0,
  output logic          pwm1,
  output logic          pwm2,
  output logic          period_start
);

  typedef enum logic [1:0] {ST_OFF, ST_WARM, ST_RUN, ST_STOP} state_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [PW-1:0] PRE_LAST    = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  state_t           state;
  state_t           state_next;
  logic [SW-1:0]    settle_ctr;
  logic [PW-1:0]    pre_ctr;
  logic [WIDTH-1:0] step_ctr;
  logic [WIDTH-1:0] shadow [3];
  logic [WIDTH-1:0] active [3];
  logic [2:0]       pwm_q;

  logic step_tick;   // prescaler wraps this cycle
  logic wrap;        // last prescaler cycle of the last step of a period
  logic accept;      // duty write handshake
  logic load_active; // active follows shadow this cycle
  logic commit;      // next cycle is the first of a new RUN period
  logic run_hold;    // RUN now and RUN next cycle

  assign step_tick   = (pre_ctr == PRE_LAST);
  assign wrap        = step_tick && (step_ctr == '1);
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign load_active = (state != ST_RUN) || wrap;
  assign commit      = (state_next == ST_RUN) && load_active;
  assign run_hold    = (state == ST_RUN) && (state_next == ST_RUN);

  // Next-state decode for the power sequencing FSM.
  always_comb begin
    // NOTE: assigning the default before the case means every path drives state_next, so no latch is inferred.
    state_next = state;
    case (state)
      ST_OFF:  if (en) state_next = ST_WARM;
      ST_WARM: begin
        if (!en)                             state_next = ST_OFF;
        else if (settle_ctr == SETTLE_LAST)  state_next = ST_RUN;
      end
      ST_RUN:  if (!en) state_next = ST_STOP;
      ST_STOP: state_next = ST_OFF;
      default: state_next = ST_OFF;
    endcase
  end

  // State register plus settle, prescaler and step counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_OFF;
      settle_ctr <= '0;
      pre_ctr    <= '0;
      step_ctr   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
      state      <= state_next;
      settle_ctr <= (state == ST_WARM) ? settle_ctr + 1'b1 : '0;
      if (state == ST_RUN) begin
        pre_ctr <= step_tick ? '0 : pre_ctr + 1'b1;
        if (step_tick) step_ctr <= step_ctr + 1'b1;
      end else begin
        pre_ctr  <= '0;
        step_ctr <= '0;
      end
    end
  end

  // Duty double buffer: host writes land in shadow, active copies shadow at
  // period boundaries (and continuously while not running). A write on the
  // commit edge is seen by active only at the following boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the duty arrays are plain registers that must read back as zero after reset, so they are cleared explicitly.
      for (int k = 0; k < 3; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (load_active)                      active[k] <= shadow[k];
        if (accept && (wr.wr_chan == 2'(k)))  shadow[k] <= wr.wr_duty;
      end
    end
  end

  // Registered outputs, decoded from the next state so enables and PWM move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr.wr_ready  <= 1'b0;
      curren       <= 1'b0;
      rgbleden     <= 1'b0;
      period_start <= 1'b0;
      pwm_q        <= '0;
    end else begin
      wr.wr_ready  <= 1'b1;
      curren       <= (state_next != ST_OFF);
      rgbleden     <= (state_next == ST_RUN);
      period_start <= commit;
      for (int k = 0; k < 3; k++) begin
        pwm_q[k] <= run_hold && (step_ctr < active[k]);
      end
    end
  end

  assign pwm0 = pwm_q[0];
  assign pwm1 = pwm_q[1];
  assign pwm2 = pwm_q[2];

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Testbench for rgb_pwm_ctrl: directed scenarios on an 8-bit/prescale-1 instance,
// randomized writes on a 4-bit/prescale-3 instance against a period-level model.
module tb_rgb_pwm_ctrl;
  localparam int A_W = 8;
  localparam int A_P = 1;
  localparam int A_S = 16;
  localparam int A_L = (1 << A_W) * A_P;
  localparam int B_W = 4;
  localparam int B_P = 3;
  localparam int B_S = 5;
  localparam int B_L = (1 << B_W) * B_P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic curren_a, rgbleden_a, pwm0_a, pwm1_a, pwm2_a, ps_a;
  logic curren_b, rgbleden_b, pwm0_b, pwm1_b, pwm2_b, ps_b;

  int n_tests = 0;
  int n_fail  = 0;

  rgb_pwm_ctrl_if #(.WIDTH(A_W)) wr_a ();
  rgb_pwm_ctrl_if #(.WIDTH(B_W)) wr_b ();

  rgb_pwm_ctrl #(.WIDTH(A_W), .PRESCALE(A_P), .SETTLE(A_S)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .wr(wr_a),
    .curren(curren_a), .rgbleden(rgbleden_a),
    .pwm0(pwm0_a), .pwm1(pwm1_a), .pwm2(pwm2_a), .period_start(ps_a)
  );

  rgb_pwm_ctrl #(.WIDTH(B_W), .PRESCALE(B_P), .SETTLE(B_S)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .wr(wr_b),
    .curren(curren_b), .rgbleden(rgbleden_b),
    .pwm0(pwm0_b), .pwm1(pwm1_b), .pwm2(pwm2_b), .period_start(ps_b)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [1:0] ch, input logic [A_W-1:0] d);
    wr_a.wr_valid = 1'b1;
    wr_a.wr_chan  = ch;
    wr_a.wr_duty  = d;
    next_cycle();
    wr_a.wr_valid = 1'b0;
  endtask

  // Step until rgbleden_a rises (bounded); reports cycles waited and any
  // pwm/curren activity seen while rgbleden was still low.
  task automatic wait_run_a(output int lat, output int bad);
    lat = 0;
    bad = 0;
    while (rgbleden_a !== 1'b1 && lat < 64) begin
      if ({pwm0_a, pwm1_a, pwm2_a} !== 3'b000 || curren_a !== 1'b1) bad = 1;
      next_cycle();
      lat++;
    end
  endtask

  // Run one full period of instance A starting at a period_start sample.
  // Counts pwm high cycles on samples 1..A_L (they reflect steps 0..A_L-1),
  // optionally issues one write whose inputs are presented at sample wr_at.
  task automatic run_period_a(input int wr_at, input logic [1:0] ch, input logic [A_W-1:0] d,
                              output int h0, output int h1, output int h2, output int ps_bad);
    h0 = 0; h1 = 0; h2 = 0; ps_bad = 0;
    for (int i = 1; i <= A_L; i++) begin
      if (i - 1 == wr_at) begin
        wr_a.wr_valid = 1'b1;
        wr_a.wr_chan  = ch;
        wr_a.wr_duty  = d;
      end
      next_cycle();
      wr_a.wr_valid = 1'b0;
      h0 += int'(pwm0_a);
      h1 += int'(pwm1_a);
      h2 += int'(pwm2_a);
      if (ps_a !== (i == A_L)) ps_bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (2) next_cycle();
    n_tests++;
    if ({curren_a, rgbleden_a, pwm0_a, pwm1_a, pwm2_a, ps_a, wr_a.wr_ready} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: got %b required 0000000",
               {curren_a, rgbleden_a, pwm0_a, pwm1_a, pwm2_a, ps_a, wr_a.wr_ready});
    end
    n_tests++;
    if ({curren_b, rgbleden_b, pwm0_b, pwm1_b, pwm2_b, ps_b, wr_b.wr_ready} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got %b required 0000000",
               {curren_b, rgbleden_b, pwm0_b, pwm1_b, pwm2_b, ps_b, wr_b.wr_ready});
    end
    rst = 1'b0;
    n_tests++;
    if (wr_a.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_just_released: got %b required 0", wr_a.wr_ready);
    end
    next_cycle();
    n_tests++;
    if (wr_a.wr_ready !== 1'b1 || wr_b.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got a=%b b=%b required 1", wr_a.wr_ready, wr_b.wr_ready);
    end
  endtask

  task automatic test_power_up();
    int lat, bad;
    write_a(2'd0, 8'd0);
    write_a(2'd1, 8'd128);
    write_a(2'd2, 8'd255);
    en_a = 1'b1;
    n_tests++;
    if (curren_a !== 1'b0) begin
      n_fail++;
      $display("FAIL curren_before_edge: got %b required 0", curren_a);
    end
    next_cycle();
    n_tests++;
    if (curren_a !== 1'b1 || rgbleden_a !== 1'b0) begin
      n_fail++;
      $display("FAIL curren_rise: got curren=%b rgbleden=%b required 1/0", curren_a, rgbleden_a);
    end
    wait_run_a(lat, bad);
    n_tests++;
    if (lat != A_S) begin
      n_fail++;
      $display("FAIL settle_cycles: got %0d required %0d", lat, A_S);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL warm_outputs: pwm or curren wrong during warm-up (got %0d required 0)", bad);
    end
    n_tests++;
    if (ps_a !== 1'b1) begin
      n_fail++;
      $display("FAIL first_period_start: got %b required 1", ps_a);
    end
  endtask

  task automatic test_duty_levels();
    int h0, h1, h2, pb;
    run_period_a(-1, 2'd0, 8'd0, h0, h1, h2, pb);
    n_tests++;
    if (h0 != 0)   begin n_fail++; $display("FAIL duty0_high: got %0d required 0", h0);     end
    n_tests++;
    if (h1 != 128) begin n_fail++; $display("FAIL duty128_high: got %0d required 128", h1); end
    n_tests++;
    if (h2 != 255) begin n_fail++; $display("FAIL duty255_high: got %0d required 255", h2); end
    n_tests++;
    if (pb != 0)   begin n_fail++; $display("FAIL period_start_spacing: got %0d bad cycles required 0", pb); end
  endtask

  task automatic test_double_buffer();
    int h0, h1, h2, pb;
    run_period_a(100, 2'd1, 8'd32, h0, h1, h2, pb);
    n_tests++;
    if (h1 != 128) begin n_fail++; $display("FAIL dbuf_same_period: got %0d required 128", h1); end
    run_period_a(-1, 2'd0, 8'd0, h0, h1, h2, pb);
    n_tests++;
    if (h1 != 32) begin n_fail++; $display("FAIL dbuf_next_period: got %0d required 32", h1); end
    n_tests++;
    if (h0 != 0 || h2 != 255) begin
      n_fail++;
      $display("FAIL dbuf_other_channels: got %0d/%0d required 0/255", h0, h2);
    end
  endtask

  task automatic test_write_at_commit();
    int h0, h1, h2, pb;
    // Write accepted on the commit edge itself.
    run_period_a(A_L - 1, 2'd0, 8'd64, h0, h1, h2, pb);
    run_period_a(-1, 2'd0, 8'd0, h0, h1, h2, pb);
    n_tests++;
    if (h0 != 0) begin n_fail++; $display("FAIL commit_edge_write_held: got %0d required 0", h0); end
    run_period_a(-1, 2'd0, 8'd0, h0, h1, h2, pb);
    n_tests++;
    if (h0 != 64) begin n_fail++; $display("FAIL commit_edge_write_applied: got %0d required 64", h0); end
    // Write presented while period_start is high.
    run_period_a(0, 2'd2, 8'd10, h0, h1, h2, pb);
    n_tests++;
    if (h2 != 255) begin n_fail++; $display("FAIL ps_cycle_write_held: got %0d required 255", h2); end
    run_period_a(-1, 2'd0, 8'd0, h0, h1, h2, pb);
    n_tests++;
    if (h2 != 10) begin n_fail++; $display("FAIL ps_cycle_write_applied: got %0d required 10", h2); end
  endtask

  task automatic test_shutdown();
    repeat (20) next_cycle();
    n_tests++;
    if ({pwm0_a, pwm1_a, pwm2_a} !== 3'b110) begin
      n_fail++;
      $display("FAIL pre_shutdown_pwm: got %b required 110", {pwm0_a, pwm1_a, pwm2_a});
    end
    en_a = 1'b0;
    next_cycle();
    n_tests++;
    if ({curren_a, rgbleden_a, pwm0_a, pwm1_a, pwm2_a, ps_a} !== 6'b100000) begin
      n_fail++;
      $display("FAIL stop_cycle: got %b required 100000",
               {curren_a, rgbleden_a, pwm0_a, pwm1_a, pwm2_a, ps_a});
    end
    next_cycle();
    n_tests++;
    if ({curren_a, rgbleden_a, pwm0_a, pwm1_a, pwm2_a, ps_a} !== 6'b000000) begin
      n_fail++;
      $display("FAIL off_after_stop: got %b required 000000",
               {curren_a, rgbleden_a, pwm0_a, pwm1_a, pwm2_a, ps_a});
    end
  endtask

  task automatic test_reset_in_run();
    int lat, bad, h0, h1, h2, pb;
    en_a = 1'b1;
    next_cycle();
    wait_run_a(lat, bad);
    n_tests++;
    if (lat != A_S) begin n_fail++; $display("FAIL rewarm_settle: got %0d required %0d", lat, A_S); end
    repeat (30) next_cycle();
    n_tests++;
    if (pwm0_a !== 1'b1) begin n_fail++; $display("FAIL duty_retained: got %b required 1", pwm0_a); end
    rst = 1'b1;
    next_cycle();
    n_tests++;
    if ({curren_a, rgbleden_a, pwm0_a, pwm1_a, pwm2_a, ps_a, wr_a.wr_ready} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_in_run: got %b required 0000000",
               {curren_a, rgbleden_a, pwm0_a, pwm1_a, pwm2_a, ps_a, wr_a.wr_ready});
    end
    rst = 1'b0;
    next_cycle();
    n_tests++;
    if (curren_a !== 1'b1 || rgbleden_a !== 1'b0) begin
      n_fail++;
      $display("FAIL warm_after_reset: got curren=%b rgbleden=%b required 1/0", curren_a, rgbleden_a);
    end
    wait_run_a(lat, bad);
    n_tests++;
    if (lat != A_S || bad != 0) begin
      n_fail++;
      $display("FAIL settle_after_reset: got lat=%0d bad=%0d required %0d/0", lat, bad, A_S);
    end
    run_period_a(-1, 2'd0, 8'd0, h0, h1, h2, pb);
    n_tests++;
    if (h0 + h1 + h2 != 0) begin
      n_fail++;
      $display("FAIL duties_cleared: got %0d/%0d/%0d required 0/0/0", h0, h1, h2);
    end
  endtask

  task automatic test_reserved_channel();
    int h0, h1, h2, pb;
    n_tests++;
    if (wr_a.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reserved_ready: got %b required 1", wr_a.wr_ready); end
    run_period_a(3, 2'd3, 8'd200, h0, h1, h2, pb);
    run_period_a(5, 2'd1, 8'd77, h0, h1, h2, pb);
    n_tests++;
    if (h0 + h1 + h2 != 0) begin
      n_fail++;
      $display("FAIL reserved_discarded: got %0d/%0d/%0d required 0/0/0", h0, h1, h2);
    end
    run_period_a(-1, 2'd0, 8'd0, h0, h1, h2, pb);
    n_tests++;
    if (h0 != 0 || h1 != 77 || h2 != 0) begin
      n_fail++;
      $display("FAIL write_after_reserved: got %0d/%0d/%0d required 0/77/0", h0, h1, h2);
    end
    en_a = 1'b0;
    repeat (2) next_cycle();
  endtask

  // Randomized writes on instance B. The model holds the host-visible shadow
  // values, snapshots them at each period boundary, and predicts every output
  // from the cycle position within the period.
  task automatic test_random();
    int sh[3], act[3], act_old[3];
    int lat, stop_at, pend, pend_ch, pend_d, ch, d;
    logic [6:0] got, exp;
    logic [2:0] ep;
    for (int k = 0; k < 3; k++) sh[k] = 0;
    // Warm-up aborted by dropping en.
    en_b = 1'b1;
    next_cycle();
    n_tests++;
    if (curren_b !== 1'b1) begin n_fail++; $display("FAIL b_warm_curren: got %b required 1", curren_b); end
    en_b = 1'b0;
    next_cycle();
    n_tests++;
    if (curren_b !== 1'b0) begin n_fail++; $display("FAIL b_warm_abort: got %b required 0", curren_b); end
    // Random writes while off, reserved channel included.
    for (int n = 0; n < 6; n++) begin
      ch = $urandom_range(0, 3);
      d  = $urandom_range(0, 15);
      wr_b.wr_valid = 1'b1;
      wr_b.wr_chan  = 2'(ch);
      wr_b.wr_duty  = 4'(d);
      next_cycle();
      wr_b.wr_valid = 1'b0;
      if (ch < 3) sh[ch] = d;
    end
    en_b = 1'b1;
    next_cycle();
    lat = 0;
    while (rgbleden_b !== 1'b1 && lat < 64) begin
      next_cycle();
      lat++;
    end
    n_tests++;
    if (lat != B_S) begin n_fail++; $display("FAIL b_settle: got %0d required %0d", lat, B_S); end
    act = sh;
    act_old = sh;
    pend = 0; pend_ch = 0; pend_d = 0;
    stop_at = 4 * B_L + $urandom_range(5, B_L - 5);
    for (int t = 0; t <= stop_at; t++) begin
      if (t > 0) next_cycle();
      wr_b.wr_valid = 1'b0;
      if (t % B_L == 0) begin
        act_old = act;
        act = sh;
      end
      if (pend != 0) begin
        if (pend_ch < 3) sh[pend_ch] = pend_d;
        pend = 0;
      end
      ep = 3'b000;
      if (t > 0) begin
        for (int k = 0; k < 3; k++) begin
          if ((((t - 1) % B_L) / B_P) < ((t % B_L == 0) ? act_old[k] : act[k])) ep[k] = 1'b1;
        end
      end
      exp = {1'b1, 1'b1, 1'b1, (t % B_L == 0), ep};
      got = {wr_b.wr_ready, curren_b, rgbleden_b, ps_b, pwm2_b, pwm1_b, pwm0_b};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b_run_t%0d {ready,curren,leden,ps,pwm2..0}: got %b required %b", t, got, exp);
      end
      if ($urandom_range(0, 5) == 0) begin
        pend    = 1;
        pend_ch = $urandom_range(0, 3);
        pend_d  = $urandom_range(0, 15);
        wr_b.wr_valid = 1'b1;
        wr_b.wr_chan  = 2'(pend_ch);
        wr_b.wr_duty  = 4'(pend_d);
      end
    end
    wr_b.wr_valid = 1'b0;
    en_b = 1'b0;
    next_cycle();
    n_tests++;
    if ({curren_b, rgbleden_b, pwm0_b, pwm1_b, pwm2_b, ps_b} !== 6'b100000) begin
      n_fail++;
      $display("FAIL b_stop_cycle: got %b required 100000",
               {curren_b, rgbleden_b, pwm0_b, pwm1_b, pwm2_b, ps_b});
    end
    next_cycle();
    n_tests++;
    if ({curren_b, rgbleden_b, pwm0_b, pwm1_b, pwm2_b, ps_b} !== 6'b000000) begin
      n_fail++;
      $display("FAIL b_off: got %b required 000000",
               {curren_b, rgbleden_b, pwm0_b, pwm1_b, pwm2_b, ps_b});
    end
  endtask

  initial begin
    wr_a.wr_valid = 1'b0; wr_a.wr_chan = 2'd0; wr_a.wr_duty = '0;
    wr_b.wr_valid = 1'b0; wr_b.wr_chan = 2'd0; wr_b.wr_duty = '0;
    #1;
    test_reset();
    test_power_up();
    test_duty_levels();
    test_double_buffer();
    test_write_at_commit();
    test_shutdown();
    test_reset_in_run();
    test_reserved_channel();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rgb_pwm_ctrl.md
Name: rgb_pwm_ctrl

Overview:
- Source-side controller for the on-chip SB_RGBA_DRV LED driver.
- Generates the three PWM streams and the CURREN/RGBLEDEN enables the driver consumes, with CURREN asserted a fixed settle time before RGBLEDEN.
- Host logic writes per-channel duty values over a valid/ready port. Values are double-buffered and take effect only at PWM period boundaries, so outputs never glitch mid-period.

Parameters:
- WIDTH, 8, duty and step-counter resolution in bits; period = 2^WIDTH steps.
- PRESCALE, 4, clk cycles per PWM step (>=1).
- SETTLE, 16, clk cycles CURREN is high before RGBLEDEN asserts (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  level request to power and run the LED driver.
- wr_valid  in  1  duty write request.
- wr_ready  out  1  duty write accept.
- wr_chan  in  2  target channel 0..2; 3 is reserved.
- wr_duty  in  WIDTH  duty value, in high steps per period.
- curren  out  1  to driver CURREN.
- rgbleden  out  1  to driver RGBLEDEN.
- pwm0  out  1  to driver RGB0PWM.
- pwm1  out  1  to driver RGB1PWM.
- pwm2  out  1  to driver RGB2PWM.
- period_start  out  1  one-cycle pulse marking a period boundary (commit).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0; shadow and active duties 0; step counter, prescaler and settle counter 0; state OFF.
- wr_ready: registered; 0 during and immediately after reset, 1 thereafter.
- Write handshake: occurs on wr_valid & wr_ready. wr_chan 0..2 updates shadow[wr_chan]. wr_chan 3 is accepted and discarded.
- States and transitions:
  - OFF: all outputs 0. en=1 -> WARM.
  - WARM: curren=1 from the first WARM cycle. The settle counter runs SETTLE cycles, then -> RUN. en=0 in WARM -> OFF, with curren=0 on the next cycle.
  - RUN: curren=1, rgbleden=1. On entry, step counter and prescaler clear to 0, all active duties load from shadow, and period_start pulses. en=0 -> STOP.
  - STOP: exactly one cycle. rgbleden=0, pwm*=0, curren=1. Always -> OFF, regardless of en; a fresh en restarts at WARM.
- Prescaler: counts 0..PRESCALE-1 in RUN. A step tick occurs when it wraps to 0.
- Step counter: increments on each tick and wraps from 2^WIDTH-1 to 0.
- Commit: when the counter wraps to 0, active[k] <= shadow[k] for all k, and period_start pulses that cycle.
- Simultaneous write and commit in the same cycle: active takes the pre-write shadow. The new value commits at the next boundary.
- Outside RUN: active[k] tracks shadow[k] every cycle.
- PWM output: pwm_k registered = (state==RUN) & (step_ctr < active[k]). One-cycle latency from the counter value.
  - Duty 0: never high.
  - Duty 2^WIDTH-1: high for all but one step per period.
  - 100% duty is not representable.
- Enable ordering guarantees:
  - rgbleden never high while curren is low.
  - curren falls at least one cycle after rgbleden falls.
  - pwm* are 0 whenever rgbleden is 0.
- Reset mid-operation: all outputs 0 on the next cycle, state OFF. The warm-up sequence is required again.

Test Plan:
- Power-up (SETTLE=16): rst released, en=1 -> curren rises 1 cycle later. rgbleden rises exactly 16 cycles after curren. No pwm activity before rgbleden.
- Duty levels (WIDTH=8, PRESCALE=1): write ch0=0, ch1=128, ch2=255, then en=1. Over one full period after period_start -> pwm0 high 0 cycles, pwm1 128, pwm2 255. period_start every 256 cycles.
- Double buffering: in RUN, write ch1=32 mid-period -> current period still shows 128 high cycles on pwm1. Next period shows 32.
- Write at commit: write ch0=64 in the cycle period_start pulses -> that period pwm0 stays at the prior duty. 64 takes effect the following period.
- Shutdown: en dropped mid-period -> next cycle rgbleden=0 and pwm*=0 with curren=1. The cycle after that, curren=0.
- Reset and reserved channel:
  - rst pulsed in RUN -> all outputs 0 next cycle; duties read back as 0 (pwm stays low after re-enable with no writes).
  - wr_chan=3 write -> accepted (wr_ready=1), no channel changes.
